shift_id_stage: RTL and testbench

//   Decode-side producer for the execute-stage shift ALU. It accepts a raw 32-bit instruction over a

---
 rtl/shift_id_stage_if.sv | 49 ++++
 rtl/shift_id_stage.sv | 158 +++++++++++++++
 tb/tb_shift_id_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_id_stage_if.sv
// -----------------------------------------------------------------------------
// shift_id_stage_if
//   Handshake bundle between the fetch side, the shift decode stage and the
//   execute stage.
//
//   Upstream (fetch -> decode):
//     in_valid, in_instr[31:0], in_pc[PC_W-1:0]  driven by the producer
//     in_ready                                   driven by the decode stage
//   Downstream (decode -> execute):
//     out_valid and all out_* decoded fields     driven by the decode stage
//     out_ready                                  driven by execute
//
//   Modports:
//     master : the environment around the stage (fetch plus execute)
//     slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface shift_id_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic            out_is_shift;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rd, out_rs1, out_rs2, out_imm, out_is_shift, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rd, out_rs1, out_rs2, out_imm, out_is_shift, out_illegal
    );
endinterface

// File: rtl/shift_id_stage.sv
// -----------------------------------------------------------------------------
// shift_id_stage
//   Decode-side producer for the execute-stage shift ALU. Accepts a raw 32-bit
//   instruction, extracts opcode/func3/func7/register addresses and the I-type
//   immediate, classifies shift instructions (SLL/SRL/SRA and the immediate
//   forms) and flags illegal shift encodings. Decoded entries sit in a
//   2-entry skid-buffered output stage (output register + skid register).
//
//   Ports:
//     clk          clock, all state on the rising edge
//     rst          synchronous, active-high reset
//     flush        drops every buffered instruction (branch redirect)
//     bus          shift_id_stage_if.slave: in_* handshake from fetch,
//                  out_* decoded entry to execute
//     illegal_cnt  saturating count of accepted illegal shifts
//
//   Configuration macro:
//     SHIFT_ID_ILLEGAL_CNT_EN  defined   -> illegal_cnt is a live counter
//                              undefined -> illegal_cnt is tied to 0
// -----------------------------------------------------------------------------
module shift_id_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    shift_id_stage_if.slave    bus,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_SL  = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            is_shift;
        logic            illegal;
    } dec_t;

    // Pure decode of one instruction word; the entry carries no other state.
    function automatic dec_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        dec_t              d;
        logic signed [31:0] imm_s;
        logic              f3_shift;
        logic              f7_ok;
        d.pc     = pc;
        d.opcode = instr[6:0];
        d.func3  = instr[14:12];
        d.func7  = instr[31:25];
        d.rd     = instr[11:7];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        imm_s    = {{20{instr[31]}}, instr[31:20]};
        d.imm    = (d.opcode == OP_IMM) ? imm_s : 32'd0;
        f3_shift = (d.func3 == F3_SL) || (d.func3 == F3_SR);
        d.is_shift = ((d.opcode == OP_REG) || (d.opcode == OP_IMM)) && f3_shift;
        // Left shifts have no alternate form; right shifts allow the SRA/SRAI bit.
        if (d.func3 == F3_SL) begin
            f7_ok = (d.func7 == F7_STD);
        end else begin
            f7_ok = (d.func7 == F7_STD) || (d.func7 == F7_ALT);
        end
        d.illegal = d.is_shift && !f7_ok;
        return d;
    endfunction

    // ---- stage p0: combinational decode and handshake ----
    dec_t w_dec_p0;
    logic w_accept_p0;
    logic w_drain_p0;

    dec_t r_out_p1;
    logic r_vld_p1;
    dec_t r_skid_p1;
    logic r_skid_vld_p1;

    assign w_dec_p0     = decode(bus.in_instr, bus.in_pc);
    // Ready depends only on skid occupancy, so it never combinationally follows out_ready.
    assign bus.in_ready = !r_skid_vld_p1 && !rst;
    assign w_accept_p0  = bus.in_valid && bus.in_ready && !flush;
    assign w_drain_p0   = r_vld_p1 && bus.out_ready;

    // ---- stage p1: output register + skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_out_p1      <= '0;
            r_skid_p1     <= '0;
        end else if (flush) begin
            // A same-cycle accept or drain is discarded along with the buffer.
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
        end else if (r_skid_vld_p1) begin
            // in_ready is low here, so the only move is skid -> output.
            if (bus.out_ready) begin
                r_out_p1      <= r_skid_p1;
                r_skid_vld_p1 <= 1'b0;
            end
        end else if (w_accept_p0) begin
            if (!r_vld_p1 || bus.out_ready) begin
                r_out_p1 <= w_dec_p0;
                r_vld_p1 <= 1'b1;
            end else begin
                r_skid_p1     <= w_dec_p0;
                r_skid_vld_p1 <= 1'b1;
            end
        end else if (w_drain_p0) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid    = r_vld_p1;
    assign bus.out_pc       = r_out_p1.pc;
    assign bus.out_opcode   = r_out_p1.opcode;
    assign bus.out_func3    = r_out_p1.func3;
    assign bus.out_func7    = r_out_p1.func7;
    assign bus.out_rd       = r_out_p1.rd;
    assign bus.out_rs1      = r_out_p1.rs1;
    assign bus.out_rs2      = r_out_p1.rs2;
    assign bus.out_imm      = r_out_p1.imm;
    assign bus.out_is_shift = r_out_p1.is_shift;
    assign bus.out_illegal  = r_out_p1.illegal;

`ifdef SHIFT_ID_ILLEGAL_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [CNT_W-1:0] r_illegal_cnt;

    // w_accept_p0 already excludes flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_accept_p0 && w_dec_p0.illegal) begin
            r_illegal_cnt <= sat_inc(r_illegal_cnt);
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_id_stage.sv
module tb_shift_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] illegal_cnt;

    shift_id_stage_if #(.PC_W(32)) bus ();

    shift_id_stage #(.PC_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [97:0]  sbq[$];
    logic         last_acc;
    logic [15:0]  cnt_exp = 16'd0;
    logic [97:0]  snap;

    // Reference decode: {pc, opcode, func3, func7, rd, rs1, rs2, imm, is_shift, illegal}
    function automatic logic [97:0] model(input logic [31:0] ins, input logic [31:0] pc);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        sh;
        logic        ill;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = (op == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : 32'h0;
        sh  = (op == 7'h33 || op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        if (!sh)            ill = 1'b0;
        else if (f3 == 3'd1) ill = (f7 != 7'h00);
        else                ill = !(f7 == 7'h00 || f7 == 7'h20);
        return {pc, op, f3, f7, ins[11:7], ins[19:15], ins[24:20], imm, sh, ill};
    endfunction

    function automatic logic [97:0] obs_vec();
        return {bus.out_pc, bus.out_opcode, bus.out_func3, bus.out_func7, bus.out_rd,
                bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_is_shift, bus.out_illegal};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: transfers are judged at the falling edge, state settles #1 after the rising edge.
    task automatic tick();
        logic        acc;
        logic        drn;
        logic [97:0] e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready && !flush && !rst;
        drn = bus.out_valid && bus.out_ready && !flush && !rst;
        if (drn) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 128'(1), 128'(0));
            end else begin
                e = sbq.pop_front();
                chk("sb_entry", 128'(obs_vec()), 128'(e));
            end
        end
        if (acc) begin
            e = model(bus.in_instr, bus.in_pc);
            sbq.push_back(e);
`ifdef SHIFT_ID_ILLEGAL_CNT_EN
            if (e[0] && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
`endif
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (flush || rst) sbq.delete();
        if (rst) cnt_exp = 16'd0;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit rnd);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        for (int k = 0; k < 20 && !done; k++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 128'(0), 128'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
        chk("drain_queue_empty", 128'(sbq.size()), 128'(0));
        chk("drain_out_valid", 128'(bus.out_valid), 128'(0));
    endtask

    logic [31:0] stream [12] = '{
        32'h00335293, // SRLI legal
        32'h40331293, // SLLI with f7=0100000 -> illegal
        32'h405251B3, // SRA legal
        32'h025251B3, // func3=101 R-type f7=0000001 -> illegal shift
        32'h405201B3, // SUB: not a shift
        32'h000091B7, // LUI with func3=001 bits: not a shift, imm 0
        32'hFFF00093, // ADDI -1: negative imm
        32'hFE0291B3, // SLL with f7=1111111 -> illegal
        32'h00629193, // SLLI legal
        32'h7FF15093, // SRLI f7=0111111 -> illegal
        32'h00A00013, // ADDI: not a shift
        32'h40F2D293  // SRAI legal
    };

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_fields", 128'(obs_vec()), 128'(0));
        chk("rst_cnt", 128'(illegal_cnt), 128'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));

        // T1 SLLI x5,x6,3
        bus.out_ready = 1'b1;
        send(32'h00331293, 32'h0000_1000, 1'b0);
        chk("t1_valid", 128'(bus.out_valid), 128'(1));
        chk("t1_is_shift", 128'(bus.out_is_shift), 128'(1));
        chk("t1_illegal", 128'(bus.out_illegal), 128'(0));
        chk("t1_rd", 128'(bus.out_rd), 128'(5));
        chk("t1_rs1", 128'(bus.out_rs1), 128'(6));
        chk("t1_func3", 128'(bus.out_func3), 128'(3'b001));
        chk("t1_imm", 128'(bus.out_imm), 128'(32'h0000_0003));
        tick();

        // T2 SRAI x1,x2,31
        send(32'h41F15093, 32'h0000_1004, 1'b0);
        chk("t2_func7", 128'(bus.out_func7), 128'(7'b0100000));
        chk("t2_imm", 128'(bus.out_imm), 128'(32'h0000_041F));
        chk("t2_is_shift", 128'(bus.out_is_shift), 128'(1));
        chk("t2_illegal", 128'(bus.out_illegal), 128'(0));
        tick();

        // T3 bad SRLI
        chk("t3_cnt_before", 128'(illegal_cnt), 128'(cnt_exp));
        send(32'h21F15093, 32'h0000_1008, 1'b0);
        chk("t3_is_shift", 128'(bus.out_is_shift), 128'(1));
        chk("t3_illegal", 128'(bus.out_illegal), 128'(1));
        chk("t3_cnt_after", 128'(illegal_cnt), 128'(cnt_exp));
        tick();

        // Legality boundaries streamed under random backpressure
        foreach (stream[i]) send(stream[i], 32'h0000_2000 + 32'(i) * 32'd4, 1'b1);
        drain();
        chk("stream_cnt", 128'(illegal_cnt), 128'(cnt_exp));

        // T4 SLL then ADDI stalled for 3 cycles
        bus.out_ready = 1'b0;
        send(32'h005211B3, 32'h0000_3000, 1'b0);
        send(32'h00100093, 32'h0000_3004, 1'b0);
        chk("t4_in_ready_full", 128'(bus.in_ready), 128'(0));
        snap = obs_vec();
        tick();
        chk("t4_stable_1", 128'(obs_vec()), 128'(snap));
        tick();
        chk("t4_stable_2", 128'(obs_vec()), 128'(snap));
        chk("t4_hold_pc", 128'(bus.out_pc), 128'(32'h0000_3000));
        chk("t4_in_ready_stall", 128'(bus.in_ready), 128'(0));
        bus.out_ready = 1'b1;
        tick();
        chk("t4_second_pc", 128'(bus.out_pc), 128'(32'h0000_3004));
        chk("t4_second_is_shift", 128'(bus.out_is_shift), 128'(0));
        chk("t4_second_illegal", 128'(bus.out_illegal), 128'(0));
        chk("t4_in_ready_release", 128'(bus.in_ready), 128'(1));
        tick();
        chk("t4_empty", 128'(bus.out_valid), 128'(0));

        // T5 flush with both entries full and a same-cycle offer
        bus.out_ready = 1'b0;
        send(32'h00331293, 32'h0000_4000, 1'b0);
        send(32'h41F15093, 32'h0000_4004, 1'b0);
        chk("t5_full", 128'(bus.in_ready), 128'(0));
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h005211B3;
        bus.in_pc    = 32'h0000_4008;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t5_in_ready", 128'(bus.in_ready), 128'(1));
        bus.out_ready = 1'b1;
        tick();
        chk("t5_nothing_accepted", 128'(bus.out_valid), 128'(0));

        // T6 reset mid-stream with two entries buffered
        bus.out_ready = 1'b0;
        send(32'h21F15093, 32'h0000_5000, 1'b0);
        send(32'h00335293, 32'h0000_5004, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_in_ready_in_rst", 128'(bus.in_ready), 128'(0));
        tick();
        chk("t6_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t6_fields", 128'(obs_vec()), 128'(0));
        chk("t6_cnt", 128'(illegal_cnt), 128'(0));
        rst = 1'b0;
        tick();
        chk("t6_in_ready_after", 128'(bus.in_ready), 128'(1));
        chk("t6_out_valid_after", 128'(bus.out_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
